// File: rtl/vram2_fetch_ctrl.sv
`default_nettype none
// vram2_fetch_ctrl: VRAM2 tile-map line fetcher with CPU writes slotted between display reads.
// Revision 1.0
module vram2_fetch_ctrl #(
  parameter int TILES = 40
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_HSTART,
  input  logic [7:0]  i_VPOS,
  input  logic [8:0]  i_SCROLLX,
  input  logic [7:0]  i_SCROLLY,
  input  logic        i_CPU_REQ,
  input  logic [11:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DATA,
  output logic        o_CPU_ACK,
  output logic [11:0] o_RAM_ADDR,
  output logic [7:0]  o_RAM_DOUT,
  input  logic [7:0]  i_RAM_DIN,
  output logic        o_RAM_WR_n,
  output logic        o_RAM_RD_n,
  output logic [7:0]  o_TILE_CODE,
  output logic [7:0]  o_TILE_ATTR,
  output logic [5:0]  o_TILE_IDX,
  output logic        o_TILE_VALID,
  output logic        o_BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SLOT_A = 3'd1,
    SLOT_B = 3'd2,
    SLOT_C = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t     state;
  logic [4:0] row;
  logic [5:0] col;
  logic [5:0] tile;
  logic [7:0] code_q;
  logic [7:0] vsum;
  logic       last_tile;
  logic       unused_bits;

  assign vsum        = i_VPOS + i_SCROLLY;
  assign last_tile   = (tile == 6'(TILES - 1));
  assign unused_bits = ^{i_SCROLLX[2:0], vsum[2:0]};

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      tile         <= '0;
      code_q       <= '0;
      o_CPU_ACK    <= 1'b0;
      o_RAM_ADDR   <= '0;
      o_RAM_DOUT   <= '0;
      o_RAM_WR_n   <= 1'b1;
      o_RAM_RD_n   <= 1'b1;
      o_TILE_CODE  <= '0;
      o_TILE_ATTR  <= '0;
      o_TILE_IDX   <= '0;
      o_TILE_VALID <= 1'b0;
      o_BUSY       <= 1'b0;
    end else begin
      o_RAM_RD_n   <= 1'b1;
      o_RAM_WR_n   <= 1'b1;
      o_CPU_ACK    <= 1'b0;
      o_TILE_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (i_HSTART) begin
            state      <= SLOT_A;
            tile       <= '0;
            row        <= vsum[7:3];
            col        <= i_SCROLLX[8:3];
            o_RAM_ADDR <= {vsum[7:3], i_SCROLLX[8:3], 1'b0};
            o_RAM_RD_n <= 1'b0;
            o_BUSY     <= 1'b1;
          end else if (i_CPU_REQ && !o_CPU_ACK) begin
            // Skipping the cycle right after an ack keeps a still-held REQ from writing twice.
            o_RAM_ADDR <= i_CPU_ADDR;
            o_RAM_DOUT <= i_CPU_DATA;
            o_RAM_WR_n <= 1'b0;
            o_CPU_ACK  <= 1'b1;
          end
        end
        SLOT_A: begin
          state      <= SLOT_B;
          o_RAM_ADDR <= {row, col, 1'b1};
          o_RAM_RD_n <= 1'b0;
        end
        SLOT_B: begin
          state  <= SLOT_C;
          code_q <= i_RAM_DIN;
          if (i_CPU_REQ) begin
            o_RAM_ADDR <= i_CPU_ADDR;
            o_RAM_DOUT <= i_CPU_DATA;
            o_RAM_WR_n <= 1'b0;
            o_CPU_ACK  <= 1'b1;
          end
        end
        SLOT_C: begin
          o_TILE_VALID <= 1'b1;
          o_TILE_CODE  <= code_q;
          o_TILE_ATTR  <= i_RAM_DIN;
          o_TILE_IDX   <= tile;
          tile         <= tile + 6'd1;
          if (last_tile) begin
            state <= DRAIN;
          end else begin
            state      <= SLOT_A;
            col        <= col + 6'd1;
            o_RAM_ADDR <= {row, col + 6'd1, 1'b0};
            o_RAM_RD_n <= 1'b0;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          o_BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/vram2_fetch_ctrl.md
# vram2_fetch_ctrl

Initiator side of the 4K×8 VRAM2 tile-map SRAM (synchronous, registered read, active-low strobes). On each line-start pulse it reads TILES (code, attribute) byte pairs for the current scanline row and streams them to the tile pipeline. It also interleaves single-byte CPU writes into fixed slots so CPU access never collides with display fetches. Sits between the CPU bus decoder, the VRAM2 SRAM and the tile shifter.

## Interface
- TILES, 40: tile entries fetched per line (1..64)
- i_MCLK  in  1  master clock; all logic on rising edge
- i_RST  in  1  reset, asynchronous, active-high
- i_HSTART  in  1  one-cycle line-start pulse
- i_VPOS  in  8  current scanline
- i_SCROLLX  in  9  horizontal scroll, pixels; [8:3] = start column
- i_SCROLLY  in  8  vertical scroll, pixels
- i_CPU_REQ  in  1  CPU write request, level, held until ack
- i_CPU_ADDR  in  12  CPU write address
- i_CPU_DATA  in  8  CPU write data
- o_CPU_ACK  out  1  one-cycle pulse in the cycle the write strobe is driven
- o_RAM_ADDR  out  12  SRAM address
- o_RAM_DOUT  out  8  SRAM write data
- i_RAM_DIN  in  8  SRAM registered read data
- o_RAM_WR_n  out  1  SRAM write strobe, active-low
- o_RAM_RD_n  out  1  SRAM read strobe, active-low
- o_TILE_CODE  out  8  fetched code byte
- o_TILE_ATTR  out  8  fetched attribute byte
- o_TILE_IDX  out  6  index of tile within line (0..TILES-1)
- o_TILE_VALID  out  1  one-cycle pulse: code/attr/idx valid
- o_BUSY  out  1  high from accepted HSTART until last tile delivered

## Operation
- Map layout: 64 cols × 32 rows × 2 bytes; address = {row[4:0], col[5:0], b}; b=0 code, b=1 attribute.
- Row = (i_VPOS + i_SCROLLY) mod 256, bits [7:3], latched on accepted HSTART. Start col = i_SCROLLX[8:3], latched likewise. Tile n column = (start + n) mod 64 (wraps 63→0).
- States: IDLE, SLOT_A, SLOT_B, SLOT_C, DRAIN.
- IDLE: HSTART → SLOT_A, tile counter 0. Else if CPU_REQ and no ack last cycle → one write cycle (WR_n low, ACK high), stay IDLE.
- SLOT_A: RD_n low, addr b=0 for current tile. → SLOT_B.
- SLOT_B: RD_n low, addr b=1. Capture i_RAM_DIN as code at end of cycle. → SLOT_C.
- SLOT_C: capture i_RAM_DIN as attribute at end of cycle. If CPU_REQ pending, perform the write (WR_n low, ACK high); RD_n high. Increment tile; → SLOT_A if tiles remain, else DRAIN.
- DRAIN: one cycle for last VALID; → IDLE, BUSY low.
- HSTART while not IDLE: ignored. HSTART and CPU_REQ together in IDLE: fetch wins; write waits for first SLOT_C.
- RD_n and WR_n are never low in the same cycle.
- Reset (any time, including mid-line): state IDLE, tile counter 0, o_RAM_WR_n=1, o_RAM_RD_n=1, o_RAM_ADDR=0, o_RAM_DOUT=0, o_CPU_ACK=0, o_TILE_VALID=0, o_TILE_CODE/ATTR=0, o_TILE_IDX=0, o_BUSY=0. No partial line resumes.

## Timing
- All outputs registered.
- SRAM read latency: address+RD_n in cycle t → data on i_RAM_DIN in cycle t+1.
- o_TILE_VALID for tile n pulses in the cycle after its SLOT_C; code, attr and idx are held until the next VALID.
- HSTART at edge 0 → first SLOT_A in cycle 1 → first VALID in cycle 4. Tile n VALID in cycle 4+3n. BUSY is high cycles 1..3·TILES+1.
- CPU write latency: ≤1 cycle in IDLE. During a line, ≤3 cycles (next SLOT_C).
- Requester drops or changes REQ the cycle after ACK. The block grants at most one write per 2 cycles in IDLE, preventing double-writes.

## Test plan
- Fetch basic: preload row 2 so code=col, attr=col^0xFF; VPOS=16, SCROLL=0, HSTART → 40 VALIDs every 3 cycles, idx 0..39, code 0..39, attr 0xFF..0xD8; first VALID 4 cycles after HSTART.
- Column wrap: SCROLLX=0x1E8 (col 61) → tiles 0..2 from cols 61,62,63, tile 3 from col 0 (addr row·128+0).
- Row wrap: VPOS=0xF8, SCROLLY=0x10 → row 1 (addresses 0x080..).
- CPU write during line: REQ addr 0x123 data 0x5A at cycle 2 after HSTART → WR_n low and ACK in cycle 3 (SLOT_C); no RD_n overlap; readback 0x5A; tile stream timing unchanged.
- CPU in IDLE + simultaneous HSTART: writes 0x000/0x11, then HSTART with REQ held → ACK only in first SLOT_C; second back-to-back IDLE request acked ≥2 cycles after the first.
- Reset mid-line at tile 10: all outputs at reset values the same cycle; no further VALIDs; a following HSTART restarts at idx 0.
